// File: rtl/nios_e_system_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit direct-control-transfer codes into 15-code packets with a
// single-entry output slot, explicit/idle flush and a sticky drop flag.
module nios_e_system_nios2_qsys_0_oci_dct_packer #(
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dct_valid,
    input  logic [1:0]  dct_code,
    input  logic        flush,
    input  logic        clear_overflow,
    input  logic        out_ready,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        pkt_valid,
    output logic [33:0] pkt_data,
    output logic        overflow
);

    localparam int IW = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = (IDLE_TIMEOUT == 0) ? '0 : IW'(IDLE_TIMEOUT - 1);

    logic [29:0]   buf_reg, buf_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          pkt_valid_reg, pkt_valid_next;
    logic [33:0]   pkt_data_reg, pkt_data_next;
    logic          overflow_reg, overflow_next;
    logic          flush_pend_reg, flush_pend_next;
    logic [IW-1:0] idle_reg, idle_next;

    logic slot_free, emit, accept, drain_empty, timeout, pend_set_ok;

    always_comb begin
        slot_free   = !pkt_valid_reg || out_ready;
        emit        = slot_free && ((cnt_reg == 4'd15) || (flush_pend_reg && (cnt_reg != 4'd0)));
        accept      = dct_valid && ((cnt_reg != 4'd15) || emit);
        drain_empty = (cnt_reg == 4'd0) && !accept;
        timeout     = (IDLE_TIMEOUT != 0) && (cnt_reg != 4'd0) && !accept && !emit
                      && (idle_reg == IDLE_LAST);
        // A flush request is meaningless if the accumulator ends up empty.
        pend_set_ok = !drain_empty && !(emit && !accept);

        buf_next        = buf_reg;
        cnt_next        = cnt_reg;
        pkt_valid_next  = pkt_valid_reg;
        pkt_data_next   = pkt_data_reg;
        overflow_next   = overflow_reg;
        flush_pend_next = flush_pend_reg;
        idle_next       = idle_reg;

        if (emit) begin
            pkt_data_next  = {cnt_reg, buf_reg};
            pkt_valid_next = 1'b1;
            buf_next       = accept ? {28'b0, dct_code} : 30'b0;
            cnt_next       = accept ? 4'd1 : 4'd0;
        end else begin
            if (accept) begin
                buf_next = {buf_reg[27:0], dct_code};
                cnt_next = cnt_reg + 4'd1;
            end
            if (pkt_valid_reg && out_ready)
                pkt_valid_next = 1'b0;
        end

        // Set wins over clear so a drop is never lost.
        if (dct_valid && !accept)
            overflow_next = 1'b1;
        else if (clear_overflow)
            overflow_next = 1'b0;

        if (accept || (cnt_reg == 4'd0))
            idle_next = '0;
        else if (idle_reg != IDLE_MAX)
            idle_next = idle_reg + IW'(1);

        if (emit || drain_empty)
            flush_pend_next = 1'b0;
        if ((flush || timeout) && pend_set_ok)
            flush_pend_next = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_reg        <= '0;
            cnt_reg        <= '0;
            pkt_valid_reg  <= 1'b0;
            pkt_data_reg   <= '0;
            overflow_reg   <= 1'b0;
            flush_pend_reg <= 1'b0;
            idle_reg       <= '0;
        end else begin
            buf_reg        <= buf_next;
            cnt_reg        <= cnt_next;
            pkt_valid_reg  <= pkt_valid_next;
            pkt_data_reg   <= pkt_data_next;
            overflow_reg   <= overflow_next;
            flush_pend_reg <= flush_pend_next;
            idle_reg       <= idle_next;
        end
    end

    assign dct_buffer = buf_reg;
    assign dct_count  = cnt_reg;
    assign pkt_valid  = pkt_valid_reg;
    assign pkt_data   = pkt_data_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_nios_e_system_nios2_qsys_0_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: stimulus queues expected packets,
// a negedge monitor pops and compares every consumed packet.
module tb_nios_e_system_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dct_valid = 1'b0;
    logic [1:0]  dct_code = 2'd0;
    logic        flush = 1'b0;
    logic        clear_overflow = 1'b0;
    logic        out_ready = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        pkt_valid;
    logic [33:0] pkt_data;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    nios_e_system_nios2_qsys_0_oci_dct_packer #(.IDLE_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .dct_valid(dct_valid), .dct_code(dct_code),
        .flush(flush), .clear_overflow(clear_overflow), .out_ready(out_ready),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .pkt_valid(pkt_valid),
        .pkt_data(pkt_data), .overflow(overflow)
    );

    // Monitor: a packet is consumed at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (reset_n && pkt_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_packet got=%h required=none", pkt_data);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if (pkt_data !== e) begin
                    errors++;
                    $display("FAIL packet got=%h required=%h", pkt_data, e);
                end else
                    $display("packet ok %h", pkt_data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end else
            $display("check ok %s = %h", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        dct_valid = 1'b1;
        dct_code  = c;
        tick();
        dct_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        tick();
        chk(name, 34'(exp_q.size()), 34'd0);
    endtask

    // Codes first, first+1, ... taken modulo 4, packed oldest-highest.
    function automatic logic [29:0] pack_seq(input int first, input int n);
        logic [29:0] b;
        b = '0;
        for (int k = 0; k < n; k++)
            b = {b[27:0], 2'((first + k) % 4)};
        return b;
    endfunction

    initial begin
        // Reset state
        tick();
        chk("rst_count", 34'(dct_count), 34'd0);
        chk("rst_buffer", 34'(dct_buffer), 34'd0);
        chk("rst_pkt_valid", 34'(pkt_valid), 34'd0);
        chk("rst_pkt_data", pkt_data, 34'd0);
        chk("rst_overflow", 34'(overflow), 34'd0);
        #4 reset_n = 1'b1;
        tick();

        // Full packet of code 01, output always ready
        out_ready = 1'b1;
        exp_q.push_back({4'hF, 30'h15555555});
        dct_valid = 1'b1;
        dct_code  = 2'b01;
        for (int i = 0; i < 15; i++) tick();
        dct_valid = 1'b0;
        chk("full_count15", 34'(dct_count), 34'd15);
        chk("full_not_yet_valid", 34'(pkt_valid), 34'd0);
        tick();
        chk("full_valid_next_edge", 34'(pkt_valid), 34'd1);
        chk("full_count_restart", 34'(dct_count), 34'd0);
        wait_drain("full_drain");

        // Three codes then explicit flush
        exp_q.push_back({4'h3, 24'b0, 6'b101101});
        send(2'b10);
        send(2'b11);
        send(2'b01);
        chk("flush_pre_buffer", 34'(dct_buffer), 34'h2D);
        pulse_flush();
        wait_drain("flush_drain");
        chk("flush_count_zero", 34'(dct_count), 34'd0);

        // Backpressure: 31 codes, first packet held, last code dropped
        out_ready = 1'b0;
        dct_valid = 1'b1;
        for (int i = 0; i < 31; i++) begin
            dct_code = 2'(i % 4);
            tick();
        end
        dct_valid = 1'b0;
        chk("bp_overflow_set", 34'(overflow), 34'd1);
        chk("bp_count_full", 34'(dct_count), 34'd15);
        chk("bp_buffer_unchanged", 34'(dct_buffer), 34'(pack_seq(15, 15)));
        chk("bp_pkt_valid", 34'(pkt_valid), 34'd1);
        repeat (5) tick();
        chk("bp_pkt_held", pkt_data, {4'hF, pack_seq(0, 15)});
        chk("bp_overflow_sticky", 34'(overflow), 34'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("bp_overflow_cleared", 34'(overflow), 34'd0);
        dct_valid = 1'b1;
        dct_code = 2'b11;
        clear_overflow = 1'b1;
        tick();
        dct_valid = 1'b0;
        clear_overflow = 1'b0;
        chk("bp_set_beats_clear", 34'(overflow), 34'd1);
        chk("bp_drop_keeps_buffer", 34'(dct_buffer), 34'(pack_seq(15, 15)));
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        exp_q.push_back({4'hF, pack_seq(0, 15)});
        exp_q.push_back({4'hF, pack_seq(15, 15)});
        out_ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_overflow_final", 34'(overflow), 34'd0);

        // Idle timeout auto-flush
        exp_q.push_back({4'h1, 30'h3});
        send(2'b11);
        repeat (3) tick();
        chk("idle_no_early_flush", 34'(pkt_valid), 34'd0);
        wait_drain("idle_drain");
        chk("idle_count_zero", 34'(dct_count), 34'd0);
        pulse_flush();
        repeat (8) tick();
        chk("empty_flush_no_pkt", 34'(pkt_valid), 34'd0);

        // Code and flush in the same cycle
        exp_q.push_back({4'h3, 30'h1B});
        send(2'b01);
        send(2'b10);
        flush = 1'b1;
        send(2'b11);
        flush = 1'b0;
        wait_drain("same_cycle_drain");

        // Reset with a held packet and a partial buffer
        out_ready = 1'b0;
        send(2'b10);
        send(2'b10);
        pulse_flush();
        repeat (2) tick();
        chk("pre_rst_held", pkt_data, {4'h2, 30'hA});
        send(2'b01);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_count", 34'(dct_count), 34'd0);
        chk("async_rst_buffer", 34'(dct_buffer), 34'd0);
        chk("async_rst_valid", 34'(pkt_valid), 34'd0);
        chk("async_rst_data", pkt_data, 34'd0);
        tick();
        #3 reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("post_rst_no_pkt", 34'(pkt_valid), 34'd0);
        send(2'b01);
        chk("post_rst_count1", 34'(dct_count), 34'd1);
        chk("post_rst_buffer", 34'(dct_buffer), 34'd1);
        exp_q.push_back({4'h1, 30'h1});
        pulse_flush();
        wait_drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
